// File: rtl/sort4_ctrl.sv
// Four-entry sorter driving an external combinational ALU with a fixed 6-compare bubble network.
// Build option: define SORT_SIGNED_EN for two's-complement ordering (default is unsigned).
module sort4_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_m,
  input  logic             alu_cf,
  input  logic             alu_zf,
  input  logic             alu_sf,
  input  logic             alu_of,
  output logic [WIDTH-1:0] s0,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] s3,
  output logic             busy,
  output logic             done,
  output logic [2:0]       swaps,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a level request sampled only in IDLE; there is no ready,
  // a start seen in CMP or DONE is dropped rather than queued.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [2:0]       swaps_q, swaps_d;
  logic [WIDTH-1:0] r_q [4];
  logic [WIDTH-1:0] r_d [4];
  logic [1:0]       lo_idx;
  logic [1:0]       hi_idx;
  logic             gt;

  always_comb begin
    case (step_q)
      3'd1, 3'd4: lo_idx = 2'd1;
      3'd2:       lo_idx = 2'd2;
      default:    lo_idx = 2'd0;
    endcase
    hi_idx = lo_idx + 2'd1;
  end

  // Flags arrive combinationally for the pair currently on alu_a/alu_b.
`ifdef SORT_SIGNED_EN
  assign gt = ~(alu_sf ^ alu_of) & ~alu_zf;
`else
  assign gt = ~alu_cf & ~alu_zf;
`endif

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    if (state_q == CMP) begin
      alu_a = r_q[lo_idx];
      alu_b = r_q[hi_idx];
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    swaps_d = swaps_q;
    for (int i = 0; i < 4; i++) r_d[i] = r_q[i];
    case (state_q)
      IDLE: begin
        if (start) begin
          r_d[0]  = x0;
          r_d[1]  = x1;
          r_d[2]  = x2;
          r_d[3]  = x3;
          swaps_d = 3'd0;
          step_d  = 3'd0;
          state_d = CMP;
        end
      end
      CMP: begin
        if (gt) begin
          r_d[lo_idx] = r_q[hi_idx];
          r_d[hi_idx] = r_q[lo_idx];
          swaps_d     = swaps_q + 3'd1;
        end
        if (step_q == 3'd5) begin
          state_d = DONE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      swaps_q <= 3'd0;
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      swaps_q <= swaps_d;
      for (int i = 0; i < 4; i++) r_q[i] <= r_d[i];
    end
  end

  assign alu_m     = 3'b001;
  assign s0        = r_q[0];
  assign s1        = r_q[1];
  assign s2        = r_q[2];
  assign s3        = r_q[3];
  assign swaps     = swaps_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sort4_ctrl.sv
// Self-checking bench for sort4_ctrl: behavioural ALU, queue-sort reference model, scenario tasks.
module tb_sort4_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] x0, x1, x2, x3;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_m;
  logic         alu_cf, alu_zf, alu_sf, alu_of;
  logic [W-1:0] s0, s1, s2, s3;
  logic         busy, done;
  logic [2:0]   swaps;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_s [4];
  int           last_sw;

  sort4_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m),
    .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .busy(busy), .done(done), .swaps(swaps), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural ALU for a-b: borrow, zero, sign, signed overflow.
  logic [W:0] diff;
  always_comb begin
    diff   = {1'b0, alu_a} - {1'b0, alu_b};
    alu_cf = diff[W];
    alu_zf = (diff[W-1:0] == '0);
    alu_sf = diff[W-1];
    alu_of = (alu_a[W-1] != alu_b[W-1]) && (diff[W-1] != alu_a[W-1]);
  end

  function automatic longint key(input logic [W-1:0] v);
`ifdef SORT_SIGNED_EN
    return longint'($signed(v));
`else
    return longint'(v);
`endif
  endfunction

  // Reference: sorted order via queue sort, swap count = number of strict inversions.
  task automatic model_push(input logic [W-1:0] a0, a1, a2, a3, output int sw);
    logic [W-1:0] v [4];
    longint k[$];
    v = '{a0, a1, a2, a3};
    sw = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (key(v[i]) > key(v[j])) sw++;
    k = {};
    for (int i = 0; i < 4; i++) k.push_back(key(v[i]));
    k.sort();
    for (int i = 0; i < 4; i++) exp_q.push_back(W'(k[i]));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_start(input logic [W-1:0] a0, a1, a2, a3);
    x0 = a0; x1 = a1; x2 = a2; x3 = a3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    x0 = $urandom; x1 = $urandom; x2 = $urandom; x3 = $urandom;
  endtask

  task automatic wait_done(input string name, input int lat0);
    int lat;
    lat = lat0;
    while (done !== 1'b1 && lat < 20) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_in_sort: got %b want 1 (cycle %0d)", name, busy, lat);
      end
      cyc();
      lat++;
    end
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL %s latency: got %0d want 6 edges after start edge", name, lat);
    end
  endtask

  task automatic check_result(input string name, input int exp_sw);
    logic [W-1:0] got [4];
    logic [W-1:0] e;
    got = '{s0, s1, s2, s3};
    for (int i = 0; i < 4; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      last_s[i] = e;
      checks++;
      if (got[i] !== e) begin
        errors++;
        $display("FAIL %s s%0d: got %h want %h", name, i, got[i], e);
      end
    end
    last_sw = exp_sw;
    checks++;
    if (swaps !== 3'(exp_sw)) begin
      errors++;
      $display("FAIL %s swaps: got %0d want %0d", name, swaps, exp_sw);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b want 1", name, busy);
    end
  endtask

  task automatic check_after_done(input string name);
    cyc();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
    end
    checks++;
    if (alu_a !== '0 || alu_b !== '0 || alu_m !== 3'b001) begin
      errors++;
      $display("FAIL %s idle_alu: got a=%h b=%h m=%b want 0 0 001", name, alu_a, alu_b, alu_m);
    end
  endtask

  task automatic sort_and_check(input string name, input logic [W-1:0] a0, a1, a2, a3);
    int sw;
    model_push(a0, a1, a2, a3, sw);
    apply_start(a0, a1, a2, a3);
    wait_done(name, 0);
    check_result(name, sw);
    check_after_done(name);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    x0 = '0; x1 = '0; x2 = '0; x3 = '0;
    cyc(); cyc();
    rst = 1'b0;
    checks++;
    if ({s0, s1, s2, s3} !== '0) begin
      errors++;
      $display("FAIL reset_s: got %h %h %h %h want 0", s0, s1, s2, s3);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || swaps !== 3'd0) begin
      errors++;
      $display("FAIL reset_ctl: got busy=%b done=%b swaps=%0d want 0 0 0", busy, done, swaps);
    end
    checks++;
    if (alu_a !== '0 || alu_b !== '0 || alu_m !== 3'b001) begin
      errors++;
      $display("FAIL reset_alu: got a=%h b=%h m=%b want 0 0 001", alu_a, alu_b, alu_m);
    end
  endtask

  task automatic test_directed();
    sort_and_check("unsorted", 32'd5, 32'd3, 32'd8, 32'd1);
    checks++;
    if ({s0, s1, s2, s3} !== {32'd1, 32'd3, 32'd5, 32'd8} || swaps !== 3'd4) begin
      errors++;
      $display("FAIL unsorted_const: got %0d %0d %0d %0d sw=%0d want 1 3 5 8 sw=4", s0, s1, s2, s3, swaps);
    end
    sort_and_check("presorted", 32'd1, 32'd2, 32'd3, 32'd4);
    sort_and_check("reverse", 32'd4, 32'd3, 32'd2, 32'd1);
    checks++;
    if (swaps !== 3'd6) begin
      errors++;
      $display("FAIL reverse_const: got swaps=%0d want 6", swaps);
    end
    sort_and_check("equal", 32'd7, 32'd7, 32'd7, 32'd7);
    sort_and_check("sign", 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFB);
    checks++;
`ifdef SORT_SIGNED_EN
    if ({s0, s1, s2, s3} !== {32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd0, 32'd2}) begin
`else
    if ({s0, s1, s2, s3} !== {32'd0, 32'd2, 32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin
`endif
      errors++;
      $display("FAIL sign_const: got %h %h %h %h", s0, s1, s2, s3);
    end
  endtask

  task automatic test_idle_hold();
    start = 1'b0;
    repeat (5) cyc();
    checks++;
    if ({s0, s1, s2, s3} !== {last_s[0], last_s[1], last_s[2], last_s[3]} || swaps !== 3'(last_sw)) begin
      errors++;
      $display("FAIL idle_hold: got %h %h %h %h sw=%0d want %h %h %h %h sw=%0d",
               s0, s1, s2, s3, swaps, last_s[0], last_s[1], last_s[2], last_s[3], last_sw);
    end
  endtask

  task automatic test_start_while_busy();
    int sw;
    model_push(32'd9, 32'd6, 32'd4, 32'd2, sw);
    apply_start(32'd9, 32'd6, 32'd4, 32'd2);
    cyc(); cyc();
    x0 = 32'd1; x1 = 32'd1; x2 = 32'd1; x3 = 32'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done("busy_start", 3);
    check_result("busy_start", sw);
    check_after_done("busy_start");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_not_queued: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_sort();
    apply_start(32'd30, 32'd20, 32'd10, 32'd0);
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || swaps !== 3'd0 || {s0, s1, s2, s3} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b done=%b sw=%0d s=%h %h %h %h want all 0",
               busy, done, swaps, s0, s1, s2, s3);
    end
    cyc();
    sort_and_check("after_reset", 32'd12, 32'd3, 32'd40, 32'd3);
  endtask

  task automatic test_random();
    logic [W-1:0] v [4];
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 2))
          0: v[i] = W'($urandom_range(0, 3));
          1: v[i] = 32'h8000_0000 + W'($urandom_range(0, 4)) - 32'd2;
          default: v[i] = $urandom;
        endcase
      end
      sort_and_check("random", v[0], v[1], v[2], v[3]);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 5; n++)
      sort_and_check("b2b", $urandom, $urandom, $urandom, $urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_idle_hold();
    test_start_while_busy();
    test_reset_mid_sort();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort4_ctrl.md
# sort4_ctrl

Four-entry sorting controller that sits directly in front of the team's combinational ALU and consumes its flags. It latches four WIDTH-bit operands on a start pulse and drives pairs of them onto the ALU as a subtraction. It swaps each pair based on the returned flags, following a fixed 6-compare bubble network. It reports the ascending result with a one-cycle done pulse.

## Interface
- WIDTH, 32, operand and result width; must match the attached ALU's WIDTH.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- x0, x1, x2, x3  input  WIDTH each  unsorted operands, sampled on the accepted start edge.
- alu_a, alu_b  output  WIDTH each  operands driven to the ALU.
- alu_m  output  3  ALU op select; constant 3'b001 (a-b).
- alu_cf, alu_zf, alu_sf, alu_of  input  1 each  ALU flags for alu_a-alu_b, used combinationally in the same cycle.
- s0, s1, s2, s3  output  WIDTH each  working/result registers; s0 is the smallest when done.
- busy  output  1  high in CMP and DONE.
- done  output  1  one-cycle pulse; s0..s3 are sorted in this cycle.
- swaps  output  3  number of swaps performed in the current/last sort (0..6).

## Operation
- States: IDLE, CMP, DONE. Step counter step[2:0] is valid in CMP.
- IDLE: if start=1, then at the edge: r0..r3 <= x0..x3, swaps <= 0, step <= 0, go to CMP. start=0 stays in IDLE.
- CMP pair schedule by step: 0:(r0,r1) 1:(r1,r2) 2:(r2,r3) 3:(r0,r1) 4:(r1,r2) 5:(r0,r1).
- In CMP: alu_a = lower-index reg, alu_b = higher-index reg. In IDLE/DONE: alu_a = alu_b = 0.
- Swap condition "gt" (alu_a > alu_b) is given under Configuration. If gt, the pair is exchanged at the edge and swaps increments.
- Equal operands (alu_zf=1) never swap.
- step 5 edge goes to DONE; other steps increment step.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE.
- s0..s3 = r0..r3 continuously and hold their value in IDLE until the next accepted start. swaps also holds.
- start asserted in CMP or DONE is ignored; it is not queued.
- rst=1 at any edge, including mid-sort: state IDLE, r0..r3=0, swaps=0, step=0. The sort in progress is discarded.

## Timing
- Reset values: s0..s3=0, busy=0, done=0, swaps=0, alu_a=alu_b=0, alu_m=3'b001.
- Start accepted at edge E. busy=1 in cycles E+1 through E+7. CMP occupies cycles E+1 to E+6, one compare per cycle.
- done=1 in the cycle after edge E+6, cleared at edge E+7. Earliest next accepted start is at edge E+8.
- Fixed latency of 7 cycles from the start edge to done, independent of data.
- No registered stage exists between alu_a/alu_b and the flag inputs. The combinational path alu_a → ALU → flags → swap mux must close in one cycle.

## Configuration
- SORT_SIGNED_EN defined: signed two's-complement order. gt = ~(alu_sf ^ alu_of) & ~alu_zf.
- SORT_SIGNED_EN undefined: unsigned order. gt = ~alu_cf & ~alu_zf, where alu_cf is the borrow of a-b.
- The state machine, latency and ports are identical in both builds.

## Test plan
- Unsorted, unsigned build, x={5,3,8,1}, pulse start → done 7 cycles later, s={1,3,5,8}, swaps=4.
- Pre-sorted x={1,2,3,4} → s={1,2,3,4}, swaps=0. Reverse order x={4,3,2,1} → s={1,2,3,4}, swaps=6.
- Equal operands, x={7,7,7,7} → s unchanged, swaps=0, done still at 7 cycles.
- Sign handling, x={FFFFFFFF,2,0,FFFFFFFB}:
  - with SORT_SIGNED_EN → s={FFFFFFFB,FFFFFFFF,0,2};
  - without → s={0,2,FFFFFFFB,FFFFFFFF}.
- Start while busy: re-pulse start with new x during CMP step 2 → ignored; result and done timing are those of the first sort.
- Reset mid-sort: assert rst for one edge during CMP step 3 → busy=0, done=0, s all 0, swaps=0. A subsequent start sorts normally.
